// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder controller.
// Holds the FSM state encoding and the default operand width.
package serial_add_pkg;

    localparam int SERIAL_ADD_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fulladder.sv
// Single-bit full adder; the only arithmetic element used by the serial adder.
module fulladder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: computes {cout,sum} = a + b + cin one bit per cycle, LSB first,
// through a single shared full adder, with registered results held between operations.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = SERIAL_ADD_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH + 1);

    // Handshake: start is taken on any rising edge where the block is not busy
    // (IDLE or DONE); a, b and cin are captured only on that edge. busy is high for
    // exactly WIDTH cycles, then done pulses for one cycle while sum/cout already
    // hold the new result. start while busy is ignored.

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_shifted;
    logic [WIDTH-1:0] sum_q;
    logic             carry;
    logic             cout_q;
    logic [CW-1:0]    cnt;
    logic             fa_s;
    logic             fa_c;
    logic             load;
    logic             step;
    logic             last;

    fulladder u_fa (
        .a    (opa[0]),
        .b    (opb[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_c)
    );

    // New sum bit enters at the MSB; after WIDTH steps bit 0 sits at the LSB.
    assign res_shifted = WIDTH'({fa_s, res} >> 1);
    assign last        = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            opa    <= '0;
            opb    <= '0;
            res    <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else if (load) begin
            opa   <= a;
            opb   <= b;
            carry <= cin;
            cnt   <= '0;
        end else if (step) begin
            opa   <= opa >> 1;
            opb   <= opb >> 1;
            res   <= res_shifted;
            carry <= fa_c;
            cnt   <= cnt + CW'(1);
            if (last) begin
                sum_q  <= res_shifted;
                cout_q <= fa_c;
            end
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule
